// File: rtl/ocm_noise_reader.sv
// ocm_noise_reader
// Streaming read engine for port 2 of the 64-bit noise on-chip memory.
// It walks a window of words, unpacks each word into four 16-bit samples
// (low lane first) and emits them on a valid/ready stream. A two-word buffer
// together with the one-cycle read latency keeps one sample per cycle
// flowing under continuous ready and never loses data under backpressure.

module ocm_noise_reader #(
    parameter int DEPTH    = 8960,
    parameter int ADDR_W   = 14,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                stop,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [ADDR_W-1:0]   cfg_len,
    input  logic                cfg_loop,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_clken,
    output logic                mem_write,
    output logic [7:0]          mem_byteenable,
    input  logic [63:0]         mem_readdata,
    output logic [SAMPLE_W-1:0] smp_data,
    output logic                smp_valid,
    input  logic                smp_ready,
    output logic                busy,
    output logic                done,
    output logic [15:0]         wrap_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  remain_q, remain_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [ADDR_W-1:0]  len_q, len_d;
    logic               loop_q, loop_d;
    logic               inflight_q, inflight_d;
    logic               zdone_q, zdone_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [1:0]         lane_q, lane_d;
    logic [63:0]        buf0_q, buf0_d;
    logic [63:0]        buf1_q, buf1_d;
    logic [15:0]        wrap_q, wrap_d;

    logic [1:0]         occ;
    logic               issue;
    logic               xfer;
    logic               pop;
    logic               push;
    logic               final_xfer;
    logic               start_acc;

    // Occupancy counts words already buffered plus the read still in flight
    assign occ        = cnt_q + {1'b0, inflight_q};
    assign issue      = (state_q == RUN) && (occ < 2'd2) && !stop;
    assign smp_valid  = (cnt_q != 2'd0);
    assign xfer       = smp_valid && smp_ready;
    assign pop        = xfer && (lane_q == 2'd3);
    assign push       = inflight_q;
    assign final_xfer = (state_q == DRAIN) && pop && (cnt_q == 2'd1) && !inflight_q;
    assign start_acc  = (state_q == IDLE) && start && !stop;

    assign mem_address    = addr_q;
    assign mem_chipselect = issue;
    assign mem_clken      = issue;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 8'hFF;
    assign busy           = (state_q != IDLE);
    assign done           = !stop && (zdone_q || final_xfer);
    assign wrap_cnt       = wrap_q;

    // Select the current lane of the head word, lowest 16 bits first
    always_comb begin
        smp_data = buf0_q[SAMPLE_W-1:0];
        unique case (lane_q)
            2'd0: smp_data = buf0_q[SAMPLE_W-1:0];
            2'd1: smp_data = buf0_q[2*SAMPLE_W-1:SAMPLE_W];
            2'd2: smp_data = buf0_q[3*SAMPLE_W-1:2*SAMPLE_W];
            2'd3: smp_data = buf0_q[4*SAMPLE_W-1:3*SAMPLE_W];
        endcase
    end

    // Next-state logic: FSM, address walker, word buffer and lane counter; stop overrides all
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        base_d     = base_q;
        len_d      = len_q;
        loop_d     = loop_q;
        inflight_d = issue;
        zdone_d    = 1'b0;
        cnt_d      = cnt_q;
        lane_d     = xfer ? (lane_q + 2'd1) : lane_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        wrap_d     = wrap_q;

        if (pop && push) begin
            if (cnt_q == 2'd2) begin
                buf0_d = buf1_q;
                buf1_d = mem_readdata;
            end else begin
                buf0_d = mem_readdata;
            end
        end else if (pop) begin
            buf0_d = buf1_q;
            cnt_d  = cnt_q - 2'd1;
        end else if (push) begin
            if (cnt_q == 2'd0) begin
                buf0_d = mem_readdata;
            end else begin
                buf1_d = mem_readdata;
            end
            cnt_d = cnt_q + 2'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (start_acc) begin
                    wrap_d   = 16'd0;
                    base_d   = cfg_base;
                    len_d    = cfg_len;
                    loop_d   = cfg_loop;
                    addr_d   = cfg_base;
                    remain_d = cfg_len;
                    if (cfg_len != '0) begin
                        state_d = RUN;
                    end else begin
                        zdone_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    if (remain_q == ONE_ADDR) begin
                        if (loop_q) begin
                            addr_d   = base_q;
                            remain_d = len_q;
                            if (wrap_q != 16'hFFFF) begin
                                wrap_d = wrap_q + 16'd1;
                            end
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        addr_d   = (addr_q == LAST_ADDR) ? '0 : (addr_q + ONE_ADDR);
                        remain_d = remain_q - ONE_ADDR;
                    end
                end
            end
            DRAIN: begin
                if (final_xfer) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (stop) begin
            state_d    = IDLE;
            cnt_d      = 2'd0;
            lane_d     = 2'd0;
            inflight_d = 1'b0;
            zdone_d    = 1'b0;
        end
    end

    // State registers, cleared asynchronously so a mid-run reset discards everything
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            base_q     <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            inflight_q <= 1'b0;
            zdone_q    <= 1'b0;
            cnt_q      <= 2'd0;
            lane_q     <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            wrap_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            base_q     <= base_d;
            len_q      <= len_d;
            loop_q     <= loop_d;
            inflight_q <= inflight_d;
            zdone_q    <= zdone_d;
            cnt_q      <= cnt_d;
            lane_q     <= lane_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            wrap_q     <= wrap_d;
        end
    end

endmodule
